mult_div_unit: RTL

- Parametrised multicycle multiply/divide unit for the multicycle core; a datapath peer of the ALU.
- Implements MIPS MULT, MULTU, DIV and DIVU. Results go into internal HI/LO registers, which MFHI/MFLO read through the MemToReg mux.
- The control unit starts an operation and waits on busy/done.
- Division by zero raises a one-cycle flag that the control unit uses to take the EPC exception path.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
// The master drives the operation request; the slave returns HI/LO and status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract
// step per cycle on unsigned magnitudes, then a single sign-fix cycle into HI/LO.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic            clock,
    input  logic            reset,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic             op_div_reg;
    logic             neg_res_reg;
    logic             neg_rem_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] mag_reg;
    logic [WIDTH:0]   upper_reg, upper_next;
    logic [WIDTH-1:0] lower_reg, lower_next;
    logic [WIDTH-1:0] hi_reg, lo_reg;

    logic busy_c, done_c, div_zero_c, accept_c;

    // Operand decode at the start cycle
    logic             op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             divisor_zero;

    assign op_signed    = ~bus.op[0];
    assign a_neg        = op_signed & bus.a[WIDTH-1];
    assign b_neg        = op_signed & bus.b[WIDTH-1];
    assign mag_a        = a_neg ? -bus.a : bus.a;
    assign mag_b        = b_neg ? -bus.b : bus.b;
    assign divisor_zero = (bus.b == '0);

    // Iteration step: multiply shifts {upper,lower} right after a conditional add,
    // divide shifts left and keeps the trial difference when it does not borrow.
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign add_sum = upper_reg + ({1'b0, mag_reg} & {(WIDTH + 1){lower_reg[0]}});
    assign shifted = {upper_reg[WIDTH-1:0], lower_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, mag_reg};

    always_comb begin
        upper_next = upper_reg;
        lower_next = lower_reg;
        if (op_div_reg) begin
            if (diff[WIDTH]) begin
                upper_next = shifted;
                lower_next = {lower_reg[WIDTH-2:0], 1'b0};
            end else begin
                upper_next = diff;
                lower_next = {lower_reg[WIDTH-2:0], 1'b1};
            end
        end else begin
            upper_next = {1'b0, add_sum[WIDTH:1]};
            lower_next = {add_sum[0], lower_reg[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] product, product_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;
    logic [WIDTH-1:0]   hi_next, lo_next;

    assign product       = {upper_reg[WIDTH-1:0], lower_reg};
    assign product_fixed = neg_res_reg ? -product : product;
    assign quot_fixed    = neg_res_reg ? -lower_reg : lower_reg;
    assign rem_fixed     = neg_rem_reg ? -upper_reg[WIDTH-1:0] : upper_reg[WIDTH-1:0];
    assign hi_next       = op_div_reg ? rem_fixed  : product_fixed[2*WIDTH-1:WIDTH];
    assign lo_next       = op_div_reg ? quot_fixed : product_fixed[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        div_zero_c = 1'b0;
        accept_c   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept_c   = 1'b1;
                    state_next = (bus.op[1] && divisor_zero) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy_c     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                div_zero_c = zero_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg     <= '0;
            op_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            zero_reg    <= 1'b0;
            mag_reg     <= '0;
            upper_reg   <= '0;
            lower_reg   <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            if (accept_c) begin
                cnt_reg     <= CNT_W'(WIDTH);
                op_div_reg  <= bus.op[1];
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                zero_reg    <= bus.op[1] & divisor_zero;
                // Divide keeps the divisor and shifts the dividend; multiply the reverse
                mag_reg     <= bus.op[1] ? mag_b : mag_a;
                lower_reg   <= bus.op[1] ? mag_a : mag_b;
                upper_reg   <= '0;
            end
            if (state_reg == RUN) begin
                cnt_reg   <= cnt_reg - CNT_W'(1);
                upper_reg <= upper_next;
                lower_reg <= lower_next;
            end
            if (state_reg == FIX) begin
                hi_reg <= hi_next;
                lo_reg <= lo_next;
            end
        end
    end

    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.div_zero = div_zero_c;

endmodule
